keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with synchronised row inputs, multi-frame debounce, press/release event pulses and multi-key rejection. It drives the column lines one at a time, samples the active-low rows, and presents a single debounced key code plus one-cycle event strobes to game logic on the 100 MHz system clock. It supersedes the fixed 4x4, no-debounce, level-only decoder.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner_if.sv | 18 +
 rtl/keypad_debounce.sv | 119 +++++++++++
 rtl/keypad_scanner.sv | 111 +++++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: scan states, candidate key
// record, key-code width and the 4x4 hex legend.
package keypad_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_HOLD} scan_state_e;

  // One frame's key candidate; vld=0 means no key (idx held at 0 so compares are exact)
  typedef struct packed {
    logic       vld;
    logic [5:0] idx;
  } cand_t;

  function automatic int kw(input int rows, input int cols);
    int w;
    w = $clog2(rows * cols);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [3:0] hex_legend(input logic [3:0] idx);
    logic [3:0] h;
    case (idx)
      4'd0:    h = 4'h1;
      4'd1:    h = 4'h2;
      4'd2:    h = 4'h3;
      4'd3:    h = 4'hA;
      4'd4:    h = 4'h4;
      4'd5:    h = 4'h5;
      4'd6:    h = 4'h6;
      4'd7:    h = 4'hB;
      4'd8:    h = 4'h7;
      4'd9:    h = 4'h8;
      4'd10:   h = 4'h9;
      4'd11:   h = 4'hC;
      4'd12:   h = 4'h0;
      4'd13:   h = 4'hF;
      4'd14:   h = 4'hE;
      default: h = 4'hD;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and game-side signals of the scanner, bundled for port hookup.
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KW = keypad_pkg::kw(ROWS, COLS);

  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [KW-1:0]   key_code;
  logic            key_held;
  logic            key_press;
  logic            key_release;
  logic            multi;

  modport master (output row, input col, key_code, key_held, key_press, key_release, multi);
  modport slave  (input row, output col, key_code, key_held, key_press, key_release, multi);
endinterface

// File: rtl/keypad_debounce.sv
// Frame evaluation: single-key candidate extraction, multi-frame debounce,
// stable key tracking and press/release strobes.
module keypad_debounce import keypad_pkg::*; #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int HEX_MAP        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_done_i,
  input  logic [ROWS*COLS-1:0]     frame_i,
  output logic [kw(ROWS,COLS)-1:0] key_code_o,
  output logic                     key_held_o,
  output logic                     key_press_o,
  output logic                     key_release_o,
  output logic                     multi_o
);
  localparam int N  = ROWS * COLS;
  localparam int KW = kw(ROWS, COLS);
  localparam int CW = 4;
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_SCANS);
  localparam bit USE_HEX = (HEX_MAP == 1) && (ROWS == 4) && (COLS == 4);

  cand_t          cand, prev_q, prev_d, stable_q, stable_d, pend_q, pend_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_nx;
  logic [KW-1:0]  code_q, code_d;
  logic           held_q, held_d, press_q, press_d, rel_q, rel_d, multi_q, multi_d;
  logic [6:0]     ones;

  function automatic logic [KW-1:0] map_code(input logic [5:0] idx);
    if (USE_HEX) return KW'(hex_legend(idx[3:0]));
    else         return KW'(idx);
  endfunction

  always_comb begin
    ones = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + 7'(frame_i[i]);
      if (frame_i[i]) cand = '{vld: 1'b1, idx: 6'(i)};
    end
  end

  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    cnt_nx   = cnt_q;
    stable_d = stable_q;
    pend_d   = '0;
    code_d   = code_q;
    held_d   = held_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    multi_d  = multi_q;
    // Second half of a direct key-to-key change: press lands one cycle after release
    if (pend_q.vld) begin
      press_d = 1'b1;
      code_d  = map_code(pend_q.idx);
    end
    if (frame_done_i) begin
      if (ones >= 7'd2) begin
        multi_d = 1'b1;
        cnt_d   = '0;
      end else begin
        multi_d = 1'b0;
        if (cand == prev_q) cnt_nx = (cnt_q >= DB) ? DB : cnt_q + CW'(1);
        else                cnt_nx = CW'(1);
        cnt_d  = cnt_nx;
        prev_d = cand;
        if (cnt_nx == DB && cand != stable_q) begin
          stable_d = cand;
          if (!cand.vld) begin
            rel_d  = 1'b1;
            held_d = 1'b0;
          end else if (!stable_q.vld) begin
            press_d = 1'b1;
            held_d  = 1'b1;
            code_d  = map_code(cand.idx);
          end else begin
            rel_d  = 1'b1;
            pend_d = cand;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      code_q   <= '0;
      held_q   <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      code_q   <= code_d;
      held_q   <= held_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      multi_q  <= multi_d;
    end
  end

  assign key_code_o    = code_q;
  assign key_held_o    = held_q;
  assign key_press_o   = press_q;
  assign key_release_o = rel_q;
  assign multi_o       = multi_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row synchroniser and column scan FSM building one
// key frame per full column sweep, handed to the debounce block.
module keypad_scanner import keypad_pkg::*; #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_TICKS     = 100000,
  parameter int SETTLE_TICKS   = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int HEX_MAP        = 1
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.slave kp
);
  localparam int N   = ROWS * COLS;
  localparam int SW  = $clog2(SCAN_TICKS);
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_TICKS - 1);
  localparam logic [SW-1:0]   SETTLE_M1 = SW'(SETTLE_TICKS - 1);
  localparam logic [CIW-1:0]  COL_LAST  = CIW'(COLS - 1);
  localparam logic [COLS-1:0] COL0_BIT  = {1'b1, {(COLS-1){1'b0}}};

  scan_state_e     state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CIW-1:0]  cidx_q, cidx_d;
  logic [N-1:0]    frame_q, frame_d;
  logic [ROWS-1:0] row_meta_q, row_sync_q;
  logic            frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cidx_d     = cidx_q;
    frame_d    = frame_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_DRIVE;
        slot_d  = '0;
        cidx_d  = '0;
      end
      ST_DRIVE: begin
        slot_d = slot_q + 1'b1;
        if (slot_q == SETTLE_M1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        slot_d  = slot_q + 1'b1;
        state_d = ST_HOLD;
        // Frame bit r*COLS+c: row 0 is the top row, i.e. row[ROWS-1]
        for (int r = 0; r < ROWS; r++)
          frame_d[r*COLS + int'(cidx_q)] = ~row_sync_q[ROWS-1-r];
      end
      ST_HOLD: begin
        if (slot_q == SLOT_LAST) begin
          slot_d  = '0;
          state_d = ST_DRIVE;
          if (cidx_q == COL_LAST) begin
            cidx_d     = '0;
            frame_done = 1'b1;
          end else begin
            cidx_d = cidx_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      cidx_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cidx_q  <= cidx_d;
      frame_q <= frame_d;
    end
  end

  assign kp.col = (state_q == ST_IDLE) ? '1 : ~(COL0_BIT >> cidx_q);

  keypad_debounce #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_SCANS(DEBOUNCE_SCANS), .HEX_MAP(HEX_MAP)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_done_i (frame_done),
    .frame_i      (frame_q),
    .key_code_o   (kp.key_code),
    .key_held_o   (kp.key_held),
    .key_press_o  (kp.key_press),
    .key_release_o(kp.key_release),
    .multi_o      (kp.multi)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a 4x4 switch matrix, runs directed
// frame tables, a mid-frame reset sequence, and random frames vs a frame-level model.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN = 16, SETTLE = 4, DB = 2;
  localparam int FRAME = COLS * SCAN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kp();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(SCAN), .SETTLE_TICKS(SETTLE),
    .DEBOUNCE_SCANS(DB), .HEX_MAP(1)
  ) dut (.clk(clk), .rst(rst), .kp(kp));

  // Pressed switches, bit r*4+c; a pressed switch pulls its row low while its column is driven
  logic [15:0] keys;
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      kp.row[ROWS-1-r] = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !kp.col[COLS-1-c]) kp.row[ROWS-1-r] = 1'b0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Frame-level reference: keys are indices 0..15, -1 means none
  int legend[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int m_prev, m_cnt, m_stable, m_code, m_held, m_multi;

  task automatic model_reset();
    m_prev = -1; m_cnt = 0; m_stable = -1; m_code = 0; m_held = 0; m_multi = 0;
  endtask

  task automatic model_step(input logic [15:0] m, output int p, output int r);
    int n, cand;
    p = 0; r = 0;
    n = $countones(m);
    if (n >= 2) begin
      m_multi = 1;
      m_cnt = 0;
    end else begin
      m_multi = 0;
      cand = -1;
      for (int i = 0; i < 16; i++) if (m[i]) cand = i;
      if (cand == m_prev) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
      else m_cnt = 1;
      m_prev = cand;
      if (m_cnt == DB && cand != m_stable) begin
        if (m_stable >= 0) r = 1;
        if (cand >= 0) begin
          p = 1; m_held = 1; m_code = legend[cand];
        end else begin
          m_held = 0;
        end
        m_stable = cand;
      end
    end
  endtask

  typedef struct {
    int np, nr, poff, roff, held, code, multi, hall, colerr;
  } obs_t;

  // Starts at offset 2 of a frame; observes offsets 2..65 so the frame's own
  // evaluation strobes (offsets 64/65) fall inside the window.
  task automatic do_frame(input logic [15:0] m, output obs_t o);
    logic [3:0] ec;
    int off;
    keys = m;
    o = '{default: 0};
    o.hall = 1;
    for (int i = 0; i < FRAME; i++) begin
      off = 2 + i;
      ec = 4'b1000 >> ((off % FRAME) / SCAN);
      if (kp.col !== ~ec) o.colerr++;
      if (kp.key_press)   begin o.np++; o.poff = off; end
      if (kp.key_release) begin o.nr++; o.roff = off; end
      if (!kp.key_held) o.hall = 0;
      if (i == FRAME - 1) begin
        o.held = int'(kp.key_held); o.code = int'(kp.key_code); o.multi = int'(kp.multi);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string nm, input obs_t o, input int ep, input int er,
                             input int eh, input int ec, input int em, input int ehall);
    chk({nm, " press count"}, o.np, ep);
    chk({nm, " release count"}, o.nr, er);
    chk({nm, " press offset"}, o.poff, ep != 0 ? (er != 0 ? 65 : 64) : 0);
    chk({nm, " release offset"}, o.roff, er != 0 ? 64 : 0);
    chk({nm, " key_held"}, o.held, eh);
    chk({nm, " key_code"}, o.code, ec);
    chk({nm, " multi"}, o.multi, em);
    chk({nm, " held throughout"}, o.hall, ehall);
    chk({nm, " column pattern errors"}, o.colerr, 0);
  endtask

  typedef struct {
    logic [15:0] mask;
    int p, r, h, code, mu;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [15:0] m, input int p, r, h, code, mu);
    vec_t v;
    v.mask = m; v.p = p; v.r = r; v.h = h; v.code = code; v.mu = mu;
    tbl.push_back(v);
  endtask

  initial begin
    obs_t o;
    int ep, er, h0, sel, strobes;
    logic [15:0] cur;

    // idle frames
    for (int i = 0; i < 10; i++) add(16'h0000, 0, 0, 0, 0, 0);
    // key "6": press after 2 frames, release after 2 frames, code retained
    add(16'h0040, 0, 0, 0, 0, 0);
    add(16'h0040, 1, 0, 1, 6, 0);
    add(16'h0040, 0, 0, 1, 6, 0);
    add(16'h0000, 0, 0, 1, 6, 0);
    add(16'h0000, 0, 1, 0, 6, 0);
    add(16'h0000, 0, 0, 0, 6, 0);
    // bounce every frame
    for (int i = 0; i < 6; i++) add((i % 2 == 0) ? 16'h0040 : 16'h0000, 0, 0, 0, 6, 0);
    // "5" and "9" together, then drop "9"
    add(16'h0420, 0, 0, 0, 6, 1);
    add(16'h0420, 0, 0, 0, 6, 1);
    add(16'h0020, 0, 0, 0, 6, 0);
    add(16'h0020, 1, 0, 1, 5, 0);
    // 5 -> 1 -> A without release, then let go
    add(16'h0001, 0, 0, 1, 5, 0);
    add(16'h0001, 1, 1, 1, 1, 0);
    add(16'h0008, 0, 0, 1, 1, 0);
    add(16'h0008, 1, 1, 1, 10, 0);
    add(16'h0008, 0, 0, 1, 10, 0);
    add(16'h0000, 0, 0, 1, 10, 0);
    add(16'h0000, 0, 1, 0, 10, 0);

    keys = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset col", int'(kp.col), 15);
    chk("reset key_code", int'(kp.key_code), 0);
    chk("reset key_held", int'(kp.key_held), 0);
    chk("reset key_press", int'(kp.key_press), 0);
    chk("reset key_release", int'(kp.key_release), 0);
    chk("reset multi", int'(kp.multi), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    h0 = 0;
    foreach (tbl[k]) begin
      do_frame(tbl[k].mask, o);
      model_step(tbl[k].mask, ep, er);
      check_frame($sformatf("vec %0d", k), o, tbl[k].p, tbl[k].r, tbl[k].h,
                  tbl[k].code, tbl[k].mu, h0 & tbl[k].h);
      h0 = tbl[k].h;
    end

    // half-debounced key, then a one-cycle reset mid-frame
    do_frame(16'h0040, o);
    model_step(16'h0040, ep, er);
    check_frame("pre-reset", o, 0, 0, 0, 10, 0, 0);
    strobes = 0;
    repeat (28) begin
      if (kp.key_press || kp.key_release) strobes++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst col", int'(kp.col), 15);
    chk("midrst key_code", int'(kp.key_code), 0);
    chk("midrst key_held", int'(kp.key_held), 0);
    chk("midrst multi", int'(kp.multi), 0);
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      if (kp.key_press || kp.key_release) strobes++;
      @(negedge clk);
    end
    chk("midrst strobes", strobes, 0);
    do_frame(16'h0040, o);
    model_step(16'h0040, ep, er);
    check_frame("post-reset 1", o, 0, 0, 0, 0, 0, 0);
    do_frame(16'h0040, o);
    model_step(16'h0040, ep, er);
    check_frame("post-reset 2", o, 1, 0, 1, 6, 0, 0);

    // random frames against the reference model
    cur = 16'h0040;
    for (int f = 0; f < 60; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      cur = cur;
      else if (sel < 6) cur = '0;
      else if (sel < 9) cur = 16'(1) << $urandom_range(0, 15);
      else              cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      h0 = m_held;
      do_frame(cur, o);
      model_step(cur, ep, er);
      check_frame($sformatf("rand %0d", f), o, ep, er, m_held, m_code, m_multi, h0 & m_held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
